// File: rtl/int_ctrl.sv
// int_ctrl: four-source priority interrupt controller with mask, W1C pending,
// in-service tracking and a registered CPU request/vector interface.
module int_ctrl #(
  parameter int         NSRC     = 4,
  parameter logic [7:0] VEC_BASE = 8'h20
) (
  input  logic            CLK_WB,
  input  logic            RST_N,
  input  logic [NSRC-1:0] IRQ_IN,
  input  logic            CFG_WE,
  input  logic [1:0]      CFG_ADDR,
  input  logic [7:0]      CFG_WDATA,
  output logic [7:0]      CFG_RDATA,
  output logic            INT_REQ,
  output logic [7:0]      INT_VEC,
  input  logic            INT_ACK,
  input  logic            EOI
);

  localparam int WW = $clog2(NSRC);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } state_t;

  state_t          state_q, state_d;
  logic [NSRC-1:0] mask_q, pend_q, pend_d;
  logic [NSRC-1:0] insv_q, insv_d;
  logic [NSRC-1:0] elig, w1c, ack_clr;
  logic            gen_q;
  logic [WW-1:0]   win_q, win_d, low_idx;
  logic            any_elig, win_ok;
  logic            ack_hit, eoi_hit, req_d;
  logic            wr_mask, wr_pend, wr_ctrl;
  logic [7:0]      rd_d, vec_d;
  logic            unused_wdata;

  assign unused_wdata = ^CFG_WDATA[7:NSRC];

  assign wr_mask = CFG_WE && (CFG_ADDR == 2'd0);
  assign wr_pend = CFG_WE && (CFG_ADDR == 2'd1);
  assign wr_ctrl = CFG_WE && (CFG_ADDR == 2'd3);

  assign elig     = mask_q & pend_q & {NSRC{gen_q}};
  assign any_elig = |elig;
  assign win_ok   = elig[win_q];

  // Lowest eligible index wins.
  always_comb begin
    low_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (elig[i]) low_idx = WW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    req_d   = 1'b0;
    ack_hit = 1'b0;
    eoi_hit = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_elig) begin
          state_d = REQ;
          win_d   = low_idx;
        end
      end
      REQ: begin
        if (INT_ACK) begin
          ack_hit = 1'b1;
          state_d = SERVICE;
        end else if (!win_ok) begin
          state_d = IDLE;
        end else begin
          req_d = 1'b1;
        end
      end
      SERVICE: begin
        if (EOI) begin
          eoi_hit = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new event in the same cycle beats both W1C and ACK clears.
  assign w1c     = wr_pend ? CFG_WDATA[NSRC-1:0] : '0;
  assign ack_clr = ack_hit ? (NSRC'(1) << win_q) : '0;
  assign pend_d  = (pend_q & ~(w1c | ack_clr)) | IRQ_IN;

  always_comb begin
    insv_d = insv_q;
    if (eoi_hit) insv_d = '0;
    else if (ack_hit) insv_d = ack_clr;
  end

  assign vec_d = (state_d == IDLE) ? 8'h00
               : VEC_BASE + 8'(win_d);

  always_comb begin
    rd_d = 8'h00;
    unique case (CFG_ADDR)
      2'd0: rd_d = 8'(mask_q);
      2'd1: rd_d = 8'(pend_q);
      2'd2: rd_d = 8'(insv_q);
      2'd3: rd_d = {7'b0, gen_q};
      default: rd_d = 8'h00;
    endcase
  end

  always_ff @(posedge CLK_WB or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      win_q     <= '0;
      mask_q    <= '0;
      gen_q     <= 1'b0;
      pend_q    <= '0;
      insv_q    <= '0;
      INT_REQ   <= 1'b0;
      INT_VEC   <= 8'h00;
      CFG_RDATA <= 8'h00;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      pend_q    <= pend_d;
      insv_q    <= insv_d;
      INT_REQ   <= req_d;
      INT_VEC   <= vec_d;
      CFG_RDATA <= rd_d;
      if (wr_mask) mask_q <= CFG_WDATA[NSRC-1:0];
      if (wr_ctrl) gen_q <= CFG_WDATA[0];
    end
  end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter NSRC, default 4: number of interrupt sources; fixed at 4 for this release.
REQ-002 Parameter VEC_BASE, default 8'h20: vector number reported for source 0.
REQ-003 CLK_WB  input  1  single system clock; all state updates on its rising edge.
REQ-004 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-005 IRQ_IN  input  4  interrupt sources, bit 0 = timer INT_FLAG; any cycle sampled high is an event.
REQ-006 CFG_WE  input  1  config register write strobe, one write per cycle.
REQ-007 CFG_ADDR  input  2  register select: 0 MASK, 1 PENDING, 2 INSERVICE, 3 CTRL.
REQ-008 CFG_WDATA  input  8  write data.
REQ-009 CFG_RDATA  output  8  registered read data of the register at CFG_ADDR; unused bits read 0.
REQ-010 INT_REQ  output  1  interrupt request to CPU.
REQ-011 INT_VEC  output  8  vector of the requesting/in-service source.
REQ-012 INT_ACK  input  1  one-cycle CPU acknowledge of INT_REQ.
REQ-013 EOI  input  1  one-cycle end-of-interrupt from CPU.

Function
REQ-014 MASK[3:0] SHALL be R/W; source i is eligible only when MASK[i]=1.
REQ-015 CTRL[0] (GEN) SHALL be R/W global enable; CTRL[7:1] read 0.
REQ-016 PENDING[i] SHALL set on any edge where IRQ_IN[i]=1, regardless of MASK/GEN.
REQ-017 Writing PENDING with bit i=1 SHALL clear PENDING[i]; writing 0 leaves it unchanged.
REQ-018 Set SHALL win over clear: IRQ_IN[i]=1 in the same cycle as a W1C or ACK-clear leaves PENDING[i]=1.
REQ-019 INSERVICE[3:0] SHALL be read-only, one-hot or zero.
REQ-020 CFG_RDATA SHALL reflect register contents one cycle after CFG_ADDR is presented (registered read).
REQ-021 FSM states IDLE, REQ, SERVICE; reset state IDLE.
REQ-022 IDLE: if GEN=1 and (PENDING & MASK)!=0, latch winner = lowest eligible index, go to REQ.
REQ-023 REQ: INT_REQ=1, INT_VEC=VEC_BASE+winner; winner held fixed while in REQ (no preemption by higher priority).
REQ-024 REQ with INT_ACK=1: clear PENDING[winner] (subject to REQ-018), set INSERVICE[winner], INT_REQ=0, go to SERVICE.
REQ-025 REQ without ACK, if winner becomes ineligible (MASK bit 0, GEN 0, or PENDING bit cleared): INT_REQ=0, return to IDLE; ACK in the same cycle takes priority over withdrawal.
REQ-026 SERVICE: INT_REQ=0, INT_VEC holds the in-service vector; EOI=1 clears INSERVICE and goes to IDLE; no nesting.
REQ-027 EOI in IDLE or REQ and INT_ACK outside REQ SHALL be ignored.
REQ-028 Latency: IRQ_IN high at edge N -> PENDING set after N -> INT_REQ high after edge N+2 (IDLE, eligible).
REQ-029 After EOI, a next eligible pending source SHALL raise INT_REQ no earlier than two edges later (IDLE pass).
REQ-030 INT_VEC arithmetic SHALL be 8-bit modulo (VEC_BASE+index wraps).

Reset
REQ-031 RST_N=0 SHALL immediately force: state IDLE, MASK=0, PENDING=0, INSERVICE=0, GEN=0, INT_REQ=0, INT_VEC=8'h00, CFG_RDATA=8'h00.
REQ-032 Reset mid-REQ or mid-SERVICE SHALL drop INT_REQ and discard all pending/in-service state; first event after release is handled normally.

Verification
REQ-033 MASK=4'hF, GEN=1, pulse IRQ_IN=4'b0001 one cycle -> INT_REQ=1, INT_VEC=8'h20 two edges later; ACK -> PENDING=0, INSERVICE=4'b0001; EOI -> INSERVICE=0.
REQ-034 Pulse IRQ_IN=4'b1010 together -> vector 8'h21 first; after ACK+EOI -> vector 8'h23 served next.
REQ-035 MASK=4'h0, pulse IRQ_IN[2] -> PENDING=4'b0100, INT_REQ stays 0; write MASK=4'h4 -> INT_REQ=1, INT_VEC=8'h22.
REQ-036 In REQ for source 0, write PENDING=8'h01 without ACK -> INT_REQ=0, state IDLE; same write plus IRQ_IN[0]=1 same cycle -> PENDING[0] stays 1, request re-raised.
REQ-037 INT_ACK coincident with IRQ_IN[winner]=1 -> INSERVICE set and PENDING[winner] remains 1; after EOI the same vector is requested again.
REQ-038 Assert RST_N=0 while in SERVICE -> all outputs 0 same cycle, CFG reads of all registers return 8'h00 after release.
